temperature_to_sensor_solver: RTL and testbench
===============================================

Name: temperature_to_sensor_solver

Overview:
Inverse of the forward temperature model `temperature = factoryBaseTemp + factoryTempCoef * tempSensorValue`. Given a target temperature, the block finds the 4-bit sensor code that first reaches or exceeds it. It uses an iterative repeated-addition search of one step per clock, with a start/ready/done handshake. It sits beside the forward calculator and feeds threshold sensor codes to the comparator/alarm logic.

Parameters:
- SENSOR_MAX, 15, largest searchable sensor code. Must fit the 4-bit output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only while ready=1.
- factoryBaseTemp  input  8  base temperature (unsigned).
- factoryTempCoef  input  4  temperature per sensor step (unsigned).
- targetTemp  input  8  temperature to invert (unsigned).
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse when results are valid.
- sensorValue  output  4  solved sensor code.
- exact  output  1  base + coef*sensorValue == targetTemp.
- underRange  output  1  targetTemp < factoryBaseTemp.
- overRange  output  1  target not reached by SENSOR_MAX.
- coefZeroErr  output  1  coef=0 and target > base.

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a rising edge:
  - state <= IDLE;
  - done, sensorValue, exact, underRange, overRange, coefZeroErr all <= 0;
  - ready = 1 after reset (decoded from state).
- Reset mid-operation: the search is aborted and no done pulse is issued.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: latch base, coef and target; acc <= {1'b0, base} (9-bit); s <= 0; go to SEARCH.
  - Output registers hold their previous results until the next accepted start.
- SEARCH (ready=0, evaluated each cycle in this priority):
  1. acc >= target: sensorValue <= s; exact <= (acc == target); underRange <= (s == 0 && acc > target); go to DONE.
  2. else coef == 0: sensorValue <= 0; coefZeroErr <= 1; go to DONE.
  3. else s == SENSOR_MAX: sensorValue <= SENSOR_MAX; overRange <= 1; go to DONE.
  4. else: acc <= acc + coef; s <= s + 1.
- Flag clearing: all flags are cleared when a start is accepted, so each result carries only its own flags.
- DONE: done=1 for exactly one cycle, then go to IDLE. A start in DONE is ignored.
- start while not in IDLE is ignored, with no side effects.
- Arithmetic:
  - acc is 9-bit and unwrapped; the maximum is 255 + 15*15 = 480, so no overflow.
  - Comparisons are unsigned, against target zero-extended to 9 bits.
  - Target values reachable only through 8-bit wrap of the forward model are not inverted; they report overRange or a higher code.
- Latency: start sampled in cycle k.
  - SEARCH covers cycles k+1 .. k+1+n, where n is the final s.
  - done is high in cycle k+n+2.
  - Minimum: k+2. Maximum: k+17 (overRange).
- Outputs are registered, with no combinational path from inputs to outputs. ready is decoded from state only.
- Back-to-back: the earliest next accepted start is in the cycle after done, which is IDLE.

Test Plan:
1. Exact hit: reset, then base=20, coef=3, target=29, start in cycle k -> done in cycle k+5; sensorValue=3, exact=1, all other flags 0; ready=0 from k+1 through k+5.
2. Round-up: base=20, coef=3, target=30 -> sensorValue=4, exact=0, done in cycle k+6. Then target=20 -> sensorValue=0, exact=1, done in cycle k+2.
3. Range errors:
   - target=10 (base 20) -> underRange=1, sensorValue=0, exact=0.
   - target=70, coef=3 -> overRange=1, sensorValue=15, done in cycle k+17.
   - coef=0, base=20, target=25 -> coefZeroErr=1, sensorValue=0.
   - coef=0, target=20 -> exact=1, coefZeroErr=0.
4. 9-bit arithmetic: base=250, coef=15, target=255 -> sensorValue=1, exact=0, overRange=0 (acc=265, no wrap).
5. Handshake: assert start continuously across a whole operation with changed input values -> exactly one done per accepted start; inputs changed during SEARCH do not affect the result; outputs hold between operations.
6. Reset mid-search: start with target=70, pull rst_n low in cycle k+6 -> next cycle state IDLE, ready=1, all outputs 0, and no done pulse ever follows.

Source files
------------

// File: rtl/temperature_to_sensor_solver.sv
// Inverts temperature = base + coef * sensor by repeated addition, one step per clock.
// Reports the first sensor code whose temperature reaches the target, plus range/error flags.
module temperature_to_sensor_solver #(
   parameter int unsigned SENSOR_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] factoryBaseTemp,
   input  logic [3:0] factoryTempCoef,
   input  logic [7:0] targetTemp,
   output logic       ready,
   output logic       done,
   output logic [3:0] sensorValue,
   output logic       exact,
   output logic       underRange,
   output logic       overRange,
   output logic       coefZeroErr
);

   localparam logic [3:0] SMAX = 4'(SENSOR_MAX);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t     state, state_nxt;
   logic [8:0] acc;
   logic [3:0] s;
   logic [3:0] coef_q;
   logic [7:0] target_q;
   logic       hit, coef_zero, at_max;

   always_comb begin
      hit       = (acc >= {1'b0, target_q});
      coef_zero = (coef_q == '0);
      at_max    = (s == SMAX);
   end

   assign ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SEARCH;
         SEARCH:  if (hit || coef_zero || at_max) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc         <= '0;
         s           <= '0;
         coef_q      <= '0;
         target_q    <= '0;
         done        <= 1'b0;
         sensorValue <= '0;
         exact       <= 1'b0;
         underRange  <= 1'b0;
         overRange   <= 1'b0;
         coefZeroErr <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc         <= {1'b0, factoryBaseTemp};
                  s           <= '0;
                  coef_q      <= factoryTempCoef;
                  target_q    <= targetTemp;
                  exact       <= 1'b0;
                  underRange  <= 1'b0;
                  overRange   <= 1'b0;
                  coefZeroErr <= 1'b0;
               end
            end
            SEARCH: begin
               // Priority order matters: a target at or below base wins even when coef is zero.
               if (hit) begin
                  sensorValue <= s;
                  exact       <= (acc == {1'b0, target_q});
                  underRange  <= (s == '0) && (acc > {1'b0, target_q});
                  done        <= 1'b1;
               end else if (coef_zero) begin
                  sensorValue <= '0;
                  coefZeroErr <= 1'b1;
                  done        <= 1'b1;
               end else if (at_max) begin
                  sensorValue <= SMAX;
                  overRange   <= 1'b1;
                  done        <= 1'b1;
               end else begin
                  acc <= acc + {5'b0, coef_q};
                  s   <= s + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_temperature_to_sensor_solver.sv
// Randomized scoreboard bench for temperature_to_sensor_solver against a direct
// arithmetic model: first n in 0..15 with base + coef*n >= target.
module tb_temperature_to_sensor_solver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] factoryBaseTemp;
   logic [3:0] factoryTempCoef;
   logic [7:0] targetTemp;
   logic       ready, done, exact, underRange, overRange, coefZeroErr;
   logic [3:0] sensorValue;

   temperature_to_sensor_solver #(.SENSOR_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .factoryBaseTemp(factoryBaseTemp), .factoryTempCoef(factoryTempCoef),
      .targetTemp(targetTemp), .ready(ready), .done(done),
      .sensorValue(sensorValue), .exact(exact), .underRange(underRange),
      .overRange(overRange), .coefZeroErr(coefZeroErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  res;   // {sensorValue, exact, underRange, overRange, coefZeroErr}
      int unsigned k;
      int unsigned due;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  last_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int unsigned act, input int unsigned expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
      end
   endtask

   function automatic exp_t model(input int unsigned b, input int unsigned c,
                                  input int unsigned t, input int unsigned k);
      exp_t e;
      int unsigned n = 0;
      logic [3:0] sv = 0;
      bit ex = 0, un = 0, ov = 0, cz = 0, found = 0;
      if (t < b) un = 1;
      else if (c == 0) begin
         if (t == b) ex = 1;
         else cz = 1;
      end else begin
         for (int unsigned i = 0; i <= 15; i++)
            if (!found && b + c * i >= t) begin
               found = 1; n = i; sv = 4'(i); ex = (b + c * i == t);
            end
         if (!found) begin ov = 1; n = 15; sv = 4'd15; end
      end
      e.res = {sv, ex, un, ov, cz};
      e.k   = k;
      e.due = k + n + 2;
      return e;
   endfunction

   // Monitor: compares every done pulse with the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) last_res = '0;
      else begin
         if (q.size() > 0 && q[0].due < cyc) begin
            chk("missed_done", 0, 1);
            void'(q.pop_front());
         end
         if (done) begin
            chk("ready_in_done", ready, 0);
            if (q.size() == 0) chk("unexpected_done", done, 0);
            else begin
               e = q.pop_front();
               chk("latency", cyc, e.due);
               chk("sensorValue", sensorValue, e.res[7:4]);
               chk("flags", {exact, underRange, overRange, coefZeroErr}, e.res[3:0]);
               last_res = e.res;
            end
         end else begin
            chk("ready", ready, (q.size() > 0 && cyc > q[0].k) ? 0 : 1);
            if (ready)
               chk("hold", {sensorValue, exact, underRange, overRange, coefZeroErr}, last_res);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic launch(input int unsigned b, input int unsigned c, input int unsigned t);
      int unsigned w = 0;
      while (!ready && w < 50) begin step(); w++; end
      if (!ready) chk("ready_timeout", ready, 1);
      factoryBaseTemp = 8'(b); factoryTempCoef = 4'(c); targetTemp = 8'(t);
      start = 1'b1;
      q.push_back(model(b, c, t, cyc));
      step();
      start = 1'b0;
      factoryBaseTemp = 8'($urandom); factoryTempCoef = 4'($urandom); targetTemp = 8'($urandom);
   endtask

   task automatic drain();
      int unsigned w = 0;
      while (q.size() > 0 && w < 40) begin step(); w++; end
      if (q.size() > 0) chk("drain_timeout", q.size(), 0);
      step();
   endtask

   task automatic run(input int unsigned b, input int unsigned c, input int unsigned t);
      launch(b, c, t);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned b, c, t;
      rst_n = 1'b0; start = 1'b0;
      factoryBaseTemp = '0; factoryTempCoef = '0; targetTemp = '0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();

      run(20, 3, 29);
      run(20, 3, 30);
      run(20, 3, 20);
      run(20, 3, 10);
      run(20, 3, 70);
      run(20, 0, 25);
      run(20, 0, 20);
      run(250, 15, 255);
      run(0, 15, 255);
      run(255, 1, 255);
      repeat (4) step();

      // Start held high with inputs changing every cycle.
      for (int i = 0; i < 150; i++) begin
         factoryBaseTemp = 8'($urandom); factoryTempCoef = 4'($urandom);
         targetTemp = 8'(factoryBaseTemp + $urandom_range(0, 60));
         start = 1'b1;
         if (ready) q.push_back(model(factoryBaseTemp, factoryTempCoef, targetTemp, cyc));
         step();
      end
      start = 1'b0;
      drain();

      for (int i = 0; i < 300; i++) begin
         b = $urandom_range(0, 255);
         c = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
         t = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255)
                                         : (b + $urandom_range(0, 80)) % 256;
         launch(b, c, t);
         if ($urandom_range(0, 1) == 0) drain();
         else repeat ($urandom_range(0, 3)) step();
      end
      drain();

      // Abort a search with reset; no done may follow.
      launch(20, 3, 70);
      repeat (5) step();
      rst_n = 1'b0;
      q.delete();
      step();
      rst_n = 1'b1;
      repeat (30) step();
      run(20, 3, 29);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
